// File: rtl/rtmq_stack_guard_pkg.sv
// Shared RTMQ peripheral definitions used by the stack guard: bus widths,
// status-word field offsets and clear-command bit indices.
package rtmq_stack_guard_pkg;

  localparam int unsigned W_ALU = 32;
  localparam int unsigned W_REG = 32;
  localparam int unsigned W_ADR = 7;
  localparam int unsigned W_DAT = 24;
  localparam int unsigned W_DPT = 8;
  localparam int unsigned N_CLR = 3;

  localparam int unsigned STA_DPT = 0;
  localparam int unsigned STA_HWM = 8;
  localparam int unsigned STA_OVF = 16;
  localparam int unsigned STA_UDF = 17;
  localparam int unsigned STA_CNF = 18;
  localparam int unsigned STA_EMP = 19;
  localparam int unsigned STA_FUL = 20;

  localparam int unsigned CLR_STK = 0;
  localparam int unsigned CLR_HWM = 1;
  localparam int unsigned CLR_DPT = 2;

  // ALU output bus as seen by peripherals: write strobe, register address, data
  typedef struct packed {
    logic             wen;
    logic [W_ADR-1:0] adr;
    logic [W_DAT-1:0] dat;
  } alu_bus_t;

endpackage

// File: rtl/rtmq_stack_guard_gpreg.sv
// General-purpose register: captures a write to ADDR and replays its data as a
// one-cycle trigger two cycles later.
module rtmq_stack_guard_gpreg
  import rtmq_stack_guard_pkg::*;
#(
  parameter int unsigned ADDR = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W_ALU-1:0] i_alu_out,
  output logic [W_REG-1:0] o_reg_out,
  output logic             o_f_trg
);

  alu_bus_t         w_bus;
  logic             w_hit;
  logic             r_hit;
  logic [W_DAT-1:0] r_dat;
  logic             r_trg;
  logic [W_REG-1:0] r_reg;

  assign w_bus = alu_bus_t'(i_alu_out);
  assign w_hit = w_bus.wen && (w_bus.adr == W_ADR'(ADDR));

  // Stage 1 latches the decoded write, stage 2 presents it as the trigger
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit <= 1'b0;
      r_dat <= '0;
      r_trg <= 1'b0;
      r_reg <= '0;
    end else begin
      r_hit <= w_hit;
      if (w_hit) r_dat <= w_bus.dat;
      r_trg <= r_hit;
      if (r_hit) r_reg <= W_REG'(r_dat);
    end
  end

  assign o_reg_out = r_reg;
  assign o_f_trg   = r_trg;

endmodule

// File: rtl/rtmq_stack_guard.sv
// Stack occupancy/integrity monitor: live depth, high-water mark, sticky
// overflow/underflow/conflict flags, registered status word and error pulse.
module rtmq_stack_guard
  import rtmq_stack_guard_pkg::*;
#(
  parameter int unsigned ADDR  = 0,
  parameter int unsigned N_DPT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_ALU-1:0] alu_out,
  input  logic             f_psh,
  input  logic             f_pop,
  output logic [W_REG-1:0] sta_out,
  output logic             err_out
);

  localparam logic [W_DPT-1:0] DPT_MAX = W_DPT'(N_DPT);
  localparam logic [W_REG-1:0] STA_RST = W_REG'(1) << STA_EMP;

  logic [W_REG-1:0] w_reg;
  logic             w_trg;
  logic             w_unused_reg;
  logic             w_clr_stk, w_clr_hwm, w_clr_dpt;
  logic [W_DPT-1:0] w_dpt_base, w_dpt_nxt, w_hwm_nxt;
  logic             w_ovf_ev, w_udf_ev, w_cnf_ev;
  logic [W_REG-1:0] w_sta;

  logic [W_DPT-1:0] r_dpt, r_hwm;
  logic             r_ovf, r_udf, r_cnf, r_err;
  logic [W_REG-1:0] r_sta;

  rtmq_stack_guard_gpreg #(.ADDR(ADDR)) u_reg (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_alu_out (alu_out),
    .o_reg_out (w_reg),
    .o_f_trg   (w_trg)
  );

  assign w_unused_reg = ^w_reg[W_REG-1:N_CLR];
  assign w_clr_stk    = w_trg & w_reg[CLR_STK];
  assign w_clr_hwm    = w_trg & w_reg[CLR_HWM];
  assign w_clr_dpt    = w_trg & w_reg[CLR_DPT];

  // Clear is applied first, then the push/pop event acts on the cleared depth
  always_comb begin
    w_ovf_ev   = 1'b0;
    w_udf_ev   = 1'b0;
    w_cnf_ev   = f_psh & f_pop;
    w_dpt_base = w_clr_dpt ? '0 : r_dpt;
    w_dpt_nxt  = w_dpt_base;
    if (f_pop) begin
      if (w_dpt_base == '0) w_udf_ev  = 1'b1;
      else                  w_dpt_nxt = w_dpt_base - W_DPT'(1);
    end else if (f_psh) begin
      if (w_dpt_base == DPT_MAX) w_ovf_ev  = 1'b1;
      else                       w_dpt_nxt = w_dpt_base + W_DPT'(1);
    end
    w_hwm_nxt = (w_clr_hwm || (w_dpt_nxt > r_hwm)) ? w_dpt_nxt : r_hwm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dpt <= '0;
      r_hwm <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_cnf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_dpt <= w_dpt_nxt;
      r_hwm <= w_hwm_nxt;
      r_ovf <= (r_ovf & ~w_clr_stk) | w_ovf_ev;
      r_udf <= (r_udf & ~w_clr_stk) | w_udf_ev;
      r_cnf <= (r_cnf & ~w_clr_stk) | w_cnf_ev;
      r_err <= w_ovf_ev | w_udf_ev | w_cnf_ev;
    end
  end

  always_comb begin
    w_sta                    = '0;
    w_sta[STA_DPT +: W_DPT]  = r_dpt;
    w_sta[STA_HWM +: W_DPT]  = r_hwm;
    w_sta[STA_OVF]           = r_ovf;
    w_sta[STA_UDF]           = r_udf;
    w_sta[STA_CNF]           = r_cnf;
    w_sta[STA_EMP]           = (r_dpt == '0);
    w_sta[STA_FUL]           = (r_dpt == DPT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) r_sta <= STA_RST;
    else     r_sta <= w_sta;
  end

  assign sta_out = r_sta;
  assign err_out = r_err;

endmodule

// File: tb/tb_rtmq_stack_guard.sv
// Directed bench for rtmq_stack_guard: each step's expected status and error
// pulse are queued with their due cycle and checked when that cycle arrives.
module tb_rtmq_stack_guard;

  localparam int unsigned TB_ADDR  = 3;
  localparam int unsigned TB_N_DPT = 10;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out;
  logic        f_psh;
  logic        f_pop;
  logic [31:0] sta_out;
  logic        err_out;

  typedef struct {
    int          due;
    bit          is_err;
    logic [31:0] val;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  rtmq_stack_guard #(.ADDR(TB_ADDR), .N_DPT(TB_N_DPT)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_out (alu_out),
    .f_psh   (f_psh),
    .f_pop   (f_pop),
    .sta_out (sta_out),
    .err_out (err_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] sta(input int d, input int h,
                                      input bit o, input bit u, input bit c);
    logic [31:0] r;
    r        = '0;
    r[7:0]   = 8'(d);
    r[15:8]  = 8'(h);
    r[16]    = o;
    r[17]    = u;
    r[18]    = c;
    r[19]    = (d == 0);
    r[20]    = (d == int'(TB_N_DPT));
    return r;
  endfunction

  function automatic logic [31:0] wr(input int a, input int d);
    logic [31:0] r;
    r = {1'b1, 7'(a), 24'(d)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_due();
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        if (sb[i].is_err) check(sb[i].tag, {31'b0, err_out}, sb[i].val);
        else              check(sb[i].tag, sta_out, sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_due();
  endtask

  // Drive one cycle of stimulus; err_out answers at the sampling edge,
  // sta_out one edge later.
  task automatic step(input logic psh, input logic pop, input logic [31:0] alu,
                      input logic [31:0] es, input logic ee, input string tag);
    sb_t e;
    f_psh   = psh;
    f_pop   = pop;
    alu_out = alu;
    e.due = cyc + 1; e.is_err = 1'b1; e.val = 32'(ee); e.tag = {tag, "_err"};
    sb.push_back(e);
    e.due = cyc + 2; e.is_err = 1'b0; e.val = es;      e.tag = {tag, "_sta"};
    sb.push_back(e);
    tick();
  endtask

  initial begin
    rst = 1'b1; alu_out = '0; f_psh = 1'b0; f_pop = 1'b0;
    tick();
    tick();
    check("reset_sta", sta_out, 32'h0008_0000);
    check("reset_err", {31'b0, err_out}, 32'd0);
    rst = 1'b0;

    // Consecutive pushes
    step(1, 0, '0, sta(1, 1, 0, 0, 0), 0, "push1");
    step(1, 0, '0, sta(2, 2, 0, 0, 0), 0, "push2");
    step(1, 0, '0, sta(3, 3, 0, 0, 0), 0, "push3");
    for (int i = 4; i <= 10; i++) step(1, 0, '0, sta(i, i, 0, 0, 0), 0, "fill");
    step(1, 0, '0, sta(10, 10, 1, 0, 0), 1, "ovf");
    step(0, 0, '0, sta(10, 10, 1, 0, 0), 0, "ovf_idle");

    // Full clear; trigger coincides with a pop from the cleared depth
    step(0, 0, wr(TB_ADDR, 7), sta(10, 10, 1, 0, 0), 0, "clr7_wr");
    step(0, 0, '0, sta(10, 10, 1, 0, 0), 0, "clr7_wait");
    step(0, 1, '0, sta(0, 0, 0, 1, 0), 1, "clr7_udf");
    step(0, 0, '0, sta(0, 0, 0, 1, 0), 0, "udf_idle");

    // Sticky clear only
    step(0, 0, wr(TB_ADDR, 1), sta(0, 0, 0, 1, 0), 0, "clr1_wr");
    step(0, 0, '0, sta(0, 0, 0, 1, 0), 0, "clr1_wait");
    step(0, 0, '0, sta(0, 0, 0, 0, 0), 0, "clr1_done");

    // Conflict at depth 4
    for (int i = 1; i <= 4; i++) step(1, 0, '0, sta(i, i, 0, 0, 0), 0, "push_to4");
    step(1, 1, '0, sta(3, 4, 0, 0, 1), 1, "cnf");
    step(0, 0, '0, sta(3, 4, 0, 0, 1), 0, "cnf_idle");

    // Build depth 5 / hwm 7, then reset depth and hwm via D=6
    for (int i = 4; i <= 7; i++) step(1, 0, '0, sta(i, i, 0, 0, 1), 0, "push_to7");
    step(0, 1, '0, sta(6, 7, 0, 0, 1), 0, "pop6");
    step(0, 1, '0, sta(5, 7, 0, 0, 1), 0, "pop5");
    step(1, 0, wr(TB_ADDR, 6), sta(6, 7, 0, 0, 1), 0, "clr6_wr");
    step(0, 0, '0, sta(6, 7, 0, 0, 1), 0, "clr6_wait");
    step(0, 0, '0, sta(0, 0, 0, 0, 1), 0, "clr6_done");
    step(1, 0, '0, sta(1, 1, 0, 0, 1), 0, "clr6_push");

    // Depth-only clear with a push on the trigger cycle
    step(1, 0, '0, sta(2, 2, 0, 0, 1), 0, "push2b");
    step(1, 0, '0, sta(3, 3, 0, 0, 1), 0, "push3b");
    step(0, 0, wr(TB_ADDR, 4), sta(3, 3, 0, 0, 1), 0, "clr4_wr");
    step(0, 0, '0, sta(3, 3, 0, 0, 1), 0, "clr4_wait");
    step(1, 0, '0, sta(1, 3, 0, 0, 1), 0, "clr4_push");

    // Write to another address must be ignored
    step(0, 0, wr(TB_ADDR - 1, 7), sta(1, 3, 0, 0, 1), 0, "badadr_wr");
    step(0, 0, '0, sta(1, 3, 0, 0, 1), 0, "badadr_w1");
    step(0, 0, '0, sta(1, 3, 0, 0, 1), 0, "badadr_w2");
    step(0, 0, '0, sta(1, 3, 0, 0, 1), 0, "badadr_w3");

    // Mid-stream reset at depth 6 with a conflict on the reset cycle
    for (int i = 2; i <= 6; i++) step(1, 0, '0, sta(i, (i > 3) ? i : 3, 0, 0, 1), 0, "push_to6");
    step(0, 0, '0, 32'h0008_0000, 0, "pre_rst");
    rst = 1'b1;
    step(1, 1, '0, 32'h0008_0000, 0, "rst_cnf");
    rst = 1'b0;
    step(0, 0, '0, 32'h0008_0000, 0, "post_rst");
    step(1, 0, '0, sta(1, 1, 0, 0, 0), 0, "post_rst_push");
    step(0, 0, '0, sta(1, 1, 0, 0, 0), 0, "drain");
    tick();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
